fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the 8-bit fifo between N requesters, and guards the fifo's read port for one consumer. It keeps an occupancy count of reserved entries, so it never issues a write to a full fifo and never passes a read to an empty one. It sits between the requesters/consumer and the fifo instance. The fifo's own overflow output is monitored as an error check.

Parameters:
N, 4, number of requesters (2..8)
W, 8, data width, equal to the fifo data width
DEPTH, 8, fifo capacity in entries; must equal the attached fifo depth
CW (localparam), clog2(DEPTH+1), width of count
PW (localparam), clog2(N), width of the round-robin pointer

Ports:
clk  in  1  clock; all state updates on the rising edge
clr  in  1  asynchronous, active-high reset
req  in  N  request i held high while requester i has data
req_data  in  N*W  requester i data at bits [i*W +: W]; stable while req[i]=1
gnt  out  N  one-hot, one-cycle grant to the requester whose data was taken
wr  out  1  fifo write strobe (registered)
wr_data  out  W  fifo write data (registered)
rd  in  1  consumer read request
rd_out  out  1  gated read to fifo = rd & rd_ok (combinational)
rd_ok  out  1  fifo holds at least one committed entry
fifo_overflow  in  1  overflow output of the fifo
count  out  CW  reserved entries, 0..DEPTH
err  out  1  sticky protocol error

Behaviour:
- Reset (clr=1, asynchronous): gnt=0, wr=0, wr_data=0, count=0, ptr=0, err=0. A write in flight is dropped.
- The attached fifo's clrn is tied to ~clr at top level, so both reset together.
- Eligibility: elig = req & ~gnt. A requester that is granted this cycle is ignored until the next edge, so the requester has one cycle to drop or replace req/data.
- space = (count < DEPTH) | rd_out. A read accepted at this edge frees a slot for a grant at the same edge.
- Grant decision, combinational, at each edge where space=1 and elig≠0:
  - Winner i is the first set bit of elig, searching from ptr upward with wrap-around.
  - Registered effects: gnt=1<<i, wr=1, wr_data=req_data[i], ptr=(i+1) mod N.
- Otherwise at the edge: gnt=0 and wr=0; wr_data holds its value.
- Latency: req sampled at edge k; gnt and wr are high during cycle k..k+1; the fifo captures the data at edge k+1.
- Maximum throughput is one write per cycle. A single requester is limited to one write per 2 cycles by the gnt mask.
- count update: count_next = count + grant_now - rd_out. Simultaneous grant and read leave count unchanged.
- rd_ok = (count - wr) ≠ 0. An entry that is reserved but not yet written to the fifo is not readable. rd_out is never high when the fifo is empty.
- err: set when fifo_overflow=1 at an edge, or when count would exceed DEPTH (assertion path). Cleared only by clr.
- Invariants: gnt at most one-hot; gnt≠0 exactly when wr=1; 0 ≤ count ≤ DEPTH.

Decomposition:
- Shared package:
  - default constants N, W, DEPTH
  - a function for the rotating priority search, returning a valid flag and an index
- One natural sub-module, rr_pick: combinational rotating-priority encoder. Inputs are elig and ptr; outputs are a valid flag and the winner index. It is reusable by other arbiters in the design.
- The counter, grant registers and err flag stay in fifo_write_arbiter.

Test Plan:
1. Reset: clr=1 with req=4'b1111, rd=1 -> gnt=0, wr=0, count=0, rd_ok=0, rd_out=0. Release clr -> first grant goes to requester 0.
2. Single write: req=4'b0001 with data 8'he0 for one edge -> next cycle gnt=4'b0001, wr=1, wr_data=8'he0, count=1, rd_ok=0. One cycle later rd_ok=1; rd=1 -> rd_out=1 and count returns to 0.
3. Round robin: req=4'b1111 held, data a0..a3 -> wr_data sequence a0,a1,a2,a3,a0,... on consecutive cycles. gnt walks 0001,0010,0100,1000.
4. Full: req0 alone with no reads -> 8 grants, count=8, then gnt=0 with req0 still high. Assert rd for one cycle -> grant issued at the same edge, count stays 8, err=0.
5. Underflow guard: rd=1 while count=0 -> rd_out=0. In the first wr cycle after a grant from empty, rd_out=0; at the next cycle rd_out=1.
6. Error and mid-operation reset: pulse fifo_overflow -> err=1 and stays 1. Assert clr during an active wr -> wr=0, count=0 immediately, err=0.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// rtl/fifo_write_arbiter_pkg.sv - shared constants and rotating priority search
package fifo_write_arbiter_pkg;

  localparam int N_DEFAULT     = 4;
  localparam int W_DEFAULT     = 8;
  localparam int DEPTH_DEFAULT = 8;
  localparam int MAX_N         = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_result_t;

  // First set bit of elig, starting at ptr and wrapping at n (n <= MAX_N)
  function automatic rr_result_t rr_search(input logic [MAX_N-1:0] elig,
                                           input logic [2:0]       ptr,
                                           input int               n);
    rr_result_t r;
    int         j;
    r.valid = 1'b0;
    r.idx   = 3'd0;
    for (int k = 0; k < MAX_N; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !r.valid && elig[j[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational rotating-priority encoder
module rr_pick
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  rr_result_t       res;
  logic [MAX_N-1:0] elig_wide;
  logic [2:0]       ptr_wide;
  logic             unused_idx_bits;

  assign elig_wide       = MAX_N'(elig);
  assign ptr_wide        = 3'(ptr);
  assign res             = rr_search(elig_wide, ptr_wide, N);
  assign valid           = res.valid;
  assign idx             = res.idx[PW-1:0];
  assign unused_idx_bits = ^res.idx;

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin write-port arbiter and read guard for a fifo
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic           wr,
  output logic [W-1:0]   wr_data,
  input  logic           rd,
  output logic           rd_out,
  output logic           rd_ok,
  input  logic           fifo_overflow,
  output logic [CW-1:0]  count,
  output logic           err
);

  localparam int CW1 = CW + 1;

  logic [PW-1:0] ptr;
  logic [N-1:0]  elig;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic          space;
  logic          grant_now;
  logic [CW:0]   count_sum;
  logic          count_over;

  // A requester granted this cycle sits out one edge so it can update req/data
  assign elig = req & ~gnt;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The entry being written this cycle is reserved but not yet readable
  assign rd_ok     = (count - CW'(wr)) != '0;
  assign rd_out    = rd & rd_ok;
  // A read taken at this edge frees a slot for a grant at the same edge
  assign space     = (count < CW'(DEPTH)) | rd_out;
  assign grant_now = space & pick_valid;
  assign count_sum = {1'b0, count} + CW1'(grant_now) - CW1'(rd_out);
  assign count_over = count_sum > CW1'(DEPTH);

  // Grant/write registers, round-robin pointer, occupancy and sticky error
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      gnt     <= '0;
      wr      <= 1'b0;
      wr_data <= '0;
      ptr     <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      if (grant_now) begin
        gnt     <= N'(1) << pick_idx;
        wr      <= 1'b1;
        wr_data <= req_data[pick_idx*W +: W];
        ptr     <= (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
      end else begin
        gnt <= '0;
        wr  <= 1'b0;
      end
      count <= count_over ? CW'(DEPTH) : count_sum[CW-1:0];
      err   <= err | fifo_overflow | count_over;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        wr;
  logic [7:0]  wr_data;
  logic        rd;
  logic        rd_out;
  logic        rd_ok;
  logic        fifo_overflow;
  logic [3:0]  count;
  logic        err;

  int total  = 0;
  int passed = 0;

  fifo_write_arbiter #(.N(4), .W(8), .DEPTH(8)) dut (
    .clk           (clk),
    .clr           (clr),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .wr            (wr),
    .wr_data       (wr_data),
    .rd            (rd),
    .rd_out        (rd_out),
    .rd_ok         (rd_ok),
    .fifo_overflow (fifo_overflow),
    .count         (count),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
  endtask

  logic [3:0] exp_gnt [5];
  logic [7:0] exp_dat [5];
  int         grants;

  initial begin
    clr = 1'b1; req = 4'b1111; rd = 1'b1; fifo_overflow = 1'b0;
    req_data = {8'ha3, 8'ha2, 8'ha1, 8'ha0};
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wr", 32'(wr), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_rd_ok", 32'(rd_ok), 32'h0);
    check("rst_rd_out", 32'(rd_out), 32'h0);
    step();
    step();
    clr = 1'b0; rd = 1'b0;

    // round robin with all requesters held
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha0};
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_gnt[i]));
      check($sformatf("rr_data%0d", i), 32'(wr_data), 32'(exp_dat[i]));
      check($sformatf("rr_count%0d", i), 32'(count), 32'(i + 1));
    end
    check("rr_wr", 32'(wr), 32'h1);

    // single write, read guard while the entry is in flight
    req = 4'b0000;
    do_reset();
    req = 4'b0001; req_data = {24'h0, 8'he0};
    step();
    req = 4'b0000; rd = 1'b1;
    #1;
    check("sw_gnt", 32'(gnt), 32'h1);
    check("sw_wr", 32'(wr), 32'h1);
    check("sw_data", 32'(wr_data), 32'he0);
    check("sw_count", 32'(count), 32'h1);
    check("sw_rd_ok", 32'(rd_ok), 32'h0);
    check("sw_rd_out_inflight", 32'(rd_out), 32'h0);
    step();
    check("sw_rd_ok2", 32'(rd_ok), 32'h1);
    check("sw_rd_out", 32'(rd_out), 32'h1);
    step();
    check("sw_count0", 32'(count), 32'h0);
    check("uf_rd_out", 32'(rd_out), 32'h0);
    rd = 1'b0;

    // fill with one requester, then one read makes room at the same edge
    do_reset();
    req = 4'b0001;
    grants = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (gnt != 4'b0) grants++;
    end
    check("full_grants", 32'(grants), 32'd8);
    check("full_count", 32'(count), 32'd8);
    check("full_gnt0", 32'(gnt), 32'h0);
    rd = 1'b1;
    #1;
    check("full_rd_out", 32'(rd_out), 32'h1);
    step();
    rd = 1'b0;
    check("full_rd_gnt", 32'(gnt), 32'h1);
    check("full_rd_count", 32'(count), 32'd8);
    check("full_err", 32'(err), 32'h0);

    // sticky error, then reset in the middle of a write
    fifo_overflow = 1'b1;
    step();
    fifo_overflow = 1'b0;
    check("err_set", 32'(err), 32'h1);
    step();
    check("err_sticky", 32'(err), 32'h1);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("mid_wr", 32'(wr), 32'h1);
    clr = 1'b1;
    #1;
    check("clr_wr", 32'(wr), 32'h0);
    check("clr_gnt", 32'(gnt), 32'h0);
    check("clr_count", 32'(count), 32'h0);
    check("clr_err", 32'(err), 32'h0);
    req = 4'b0000;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
